// File: rtl/ris_uart_pkg.sv
// Shared definitions for the RIS command UART transmitter: packet headers,
// command type codes, serialiser state encoding and timing helpers.
package ris_uart_pkg;

  localparam logic [7:0] HDR_GPIO = 8'h47;
  localparam logic [7:0] HDR_SNR  = 8'h53;

  localparam logic CMD_GPIO = 1'b0;
  localparam logic CMD_SNR  = 1'b1;

  // ST_NEXT is the zero-time byte decision; it lives combinationally in the top.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP,
    ST_NEXT
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int frame_len(input int checksum_en);
    return (checksum_en != 0) ? 6 : 5;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with optional trailing idle bits. A new byte may be
// loaded in the same cycle byte_done fires, giving gapless back-to-back bytes.
module uart_byte_tx
  import ris_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       tx_line,
  output logic       byte_done,
  output logic       idle
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
  localparam logic [7:0] GAP_LAST_B = 8'(GAP_LAST);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       gap_idx_q, gap_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (baud_cnt_q == CNT_LAST);
  assign tx_line = tx_q;
  assign idle    = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    gap_idx_d  = gap_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    byte_done  = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (GAP_BITS > 0) begin
            state_d   = ST_GAP;
            gap_idx_d = 8'd0;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (gap_idx_q == GAP_LAST_B) begin
            byte_done = 1'b1;
          end else begin
            gap_idx_d = gap_idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    if (byte_done) begin
      state_d = ST_IDLE;
      tx_d    = 1'b1;
    end

    // Loading on byte_done skips the idle state so the next start bit is seamless.
    if (byte_valid && (state_q == ST_IDLE || byte_done)) begin
      state_d    = ST_START;
      baud_cnt_d = '0;
      shift_d    = byte_data;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      gap_idx_q  <= 8'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      gap_idx_q  <= gap_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/ris_cmd_uart_tx.sv
// Command packet initiator: frames a header, four payload bytes and an optional
// XOR checksum, and feeds them to the byte serialiser one after another.
module ris_cmd_uart_tx
  import ris_uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int CHECKSUM_EN = 1,
  parameter int GAP_BITS    = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [31:0] cmd_data,
  output logic        tx_line,
  output logic        busy,
  output logic        frame_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int N = frame_len(CHECKSUM_EN);
  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [31:0] data_q, data_d;
  logic        frame_done_q, frame_done_d;

  logic        byte_idle;
  logic        byte_done;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [7:0]  next_byte;
  logic        accept;
  logic        more;

  assign cmd_ready  = byte_idle & ~reset;
  assign busy       = ~byte_idle;
  assign frame_done = frame_done_q;

  always_comb begin
    case (byte_idx_q + 3'd1)
      3'd1:    next_byte = data_q[31:24];
      3'd2:    next_byte = data_q[23:16];
      3'd3:    next_byte = data_q[15:8];
      3'd4:    next_byte = data_q[7:0];
      3'd5:    next_byte = data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
      default: next_byte = hdr_q;
    endcase
  end

  always_comb begin
    accept       = cmd_valid & cmd_ready;
    more         = (byte_idx_q != LAST_IDX);
    byte_idx_d   = byte_idx_q;
    hdr_d        = hdr_q;
    data_d       = data_q;

    if (accept) begin
      hdr_d      = (cmd_type == CMD_SNR) ? HDR_SNR : HDR_GPIO;
      data_d     = cmd_data;
      byte_idx_d = 3'd0;
    end else if (byte_done && more) begin
      byte_idx_d = byte_idx_q + 3'd1;
    end

    // Header goes straight from the inputs so the start bit follows acceptance by one cycle.
    byte_valid   = accept | (byte_done & more);
    byte_data    = accept ? hdr_d : next_byte;
    frame_done_d = byte_done & ~more;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      byte_idx_q   <= 3'd0;
      hdr_q        <= 8'd0;
      data_q       <= 32'd0;
      frame_done_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      hdr_q        <= hdr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_byte_tx (
    .clk        (CLOCK_50),
    .srst       (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .tx_line    (tx_line),
    .byte_done  (byte_done),
    .idle       (byte_idle)
  );

endmodule

// File: tb/tb_ris_cmd_uart_tx.sv
// Directed bench: three instances (defaults, 10 clk/bit without checksum,
// 11 clk/bit with two gap bits) driven through packet, handshake and reset cases.
module tb_ris_cmd_uart_tx;

  logic        clk;
  logic        rst   [3];
  logic        valid [3];
  logic        ctype [3];
  logic [31:0] cdata [3];
  logic        ready [3];
  logic        txl   [3];
  logic        bsy   [3];
  logic        fdone [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] e [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ris_cmd_uart_tx u0 (
    .CLOCK_50(clk), .reset(rst[0]), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_type(ctype[0]), .cmd_data(cdata[0]), .tx_line(txl[0]), .busy(bsy[0]),
    .frame_done(fdone[0])
  );

  ris_cmd_uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .CHECKSUM_EN(0), .GAP_BITS(0)) u1 (
    .CLOCK_50(clk), .reset(rst[1]), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_type(ctype[1]), .cmd_data(cdata[1]), .tx_line(txl[1]), .busy(bsy[1]),
    .frame_done(fdone[1])
  );

  // 1e6/95e3 = 10.53, so correct rounding gives 11 clocks per bit.
  ris_cmd_uart_tx #(.CLK_FREQ(1000000), .BAUD(95000), .CHECKSUM_EN(1), .GAP_BITS(2)) u2 (
    .CLOCK_50(clk), .reset(rst[2]), .cmd_valid(valid[2]), .cmd_ready(ready[2]),
    .cmd_type(ctype[2]), .cmd_data(cdata[2]), .tx_line(txl[2]), .busy(bsy[2]),
    .frame_done(fdone[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has raised valid[u] at a negedge with ready high; acceptance is the next posedge.
  task automatic run_frame(input int u, input int cpb, input int gap, input int nb,
                           input logic [7:0] exp [6], input string tag, input bit disturb);
    int bitlen;
    int total;
    int b, r, bi, ph;
    int bad_frame, bad_busy, bad_ready, bad_done;
    logic [7:0] got [6];
    bitlen = (10 + gap) * cpb;
    total  = nb * bitlen;
    bad_frame = 0; bad_busy = 0; bad_ready = 0; bad_done = 0;
    @(posedge clk);
    for (int j = 0; j < total; j++) begin
      @(negedge clk);
      if (j == 0) begin
        valid[u] = 1'b0;
        chk($sformatf("%s start_latency", tag), 32'(txl[u]), 32'd0);
      end
      if (disturb && j == bitlen + 3) begin
        cdata[u] = ~cdata[u];
        ctype[u] = ~ctype[u];
        valid[u] = 1'b1;
      end
      if (disturb && j == 3 * bitlen) valid[u] = 1'b0;
      b  = j / bitlen;
      r  = j % bitlen;
      bi = r / cpb;
      ph = r % cpb;
      if (bi == 0 && ph == cpb / 2 && txl[u] !== 1'b0) bad_frame++;
      if (bi >= 1 && bi <= 8 && ph == cpb / 2) got[b][bi-1] = txl[u];
      if (bi >= 9 && txl[u] !== 1'b1) bad_frame++;
      if (bsy[u] !== 1'b1) bad_busy++;
      if (ready[u] !== 1'b0) bad_ready++;
      if (fdone[u] !== 1'b0) bad_done++;
    end
    @(negedge clk);
    chk($sformatf("%s frame_done_at_%0d", tag, total), 32'(fdone[u]), 32'd1);
    chk($sformatf("%s ready_after", tag), 32'(ready[u]), 32'd1);
    chk($sformatf("%s busy_after", tag), 32'(bsy[u]), 32'd0);
    chk($sformatf("%s line_idle_after", tag), 32'(txl[u]), 32'd1);
    for (int k = 0; k < nb; k++)
      chk($sformatf("%s byte%0d", tag, k), 32'(got[k]), 32'(exp[k]));
    chk($sformatf("%s start_stop_gap_errs", tag), bad_frame, 0);
    chk($sformatf("%s busy_low_cycles", tag), bad_busy, 0);
    chk($sformatf("%s ready_high_cycles", tag), bad_ready, 0);
    chk($sformatf("%s early_frame_done", tag), bad_done, 0);
    $display("frame %s: unit=%0d bytes=%0d cycles=%0d checked", tag, u, nb, total);
  endtask

  initial begin
    int stray;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; ctype[i] = 1'b0; cdata[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d tx_line", i), 32'(txl[i]), 32'd1);
      chk($sformatf("reset u%0d busy", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("reset u%0d frame_done", i), 32'(fdone[i]), 32'd0);
      chk($sformatf("reset u%0d ready_in_reset", i), 32'(ready[i]), 32'd0);
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("post_reset u%0d ready", i), 32'(ready[i]), 32'd1);

    // GPIO 0x12345678 at defaults: checksum 12^34^56^78 = 08, 26040 cycles.
    @(negedge clk);
    ctype[0] = 1'b0; cdata[0] = 32'h12345678; valid[0] = 1'b1;
    e = '{8'h47, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_frame(0, 434, 0, 6, e, "gpio_12345678", 1'b0);

    // Back-to-back: new command offered in the frame_done cycle.
    ctype[0] = 1'b0; cdata[0] = 32'hFFFFFFFF; valid[0] = 1'b1;
    e = '{8'h47, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    run_frame(0, 434, 0, 6, e, "b2b_ffffffff", 1'b0);
    @(negedge clk);
    chk("b2b frame_done_single_cycle", 32'(fdone[0]), 32'd0);

    // SNR 0 without checksum: five bytes.
    @(negedge clk);
    ctype[1] = 1'b1; cdata[1] = 32'h00000000; valid[1] = 1'b1;
    e = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(1, 10, 0, 5, e, "snr_zero_nocks", 1'b0);

    // Inputs change and valid pulses while busy: frame must keep latched values.
    @(negedge clk);
    ctype[1] = 1'b0; cdata[1] = 32'hA5C30F1E; valid[1] = 1'b1;
    e = '{8'h47, 8'hA5, 8'hC3, 8'h0F, 8'h1E, 8'h00};
    run_frame(1, 10, 0, 5, e, "gpio_disturbed", 1'b1);
    @(negedge clk);
    chk("disturbed no_restart busy", 32'(bsy[1]), 32'd0);

    // Reset in byte 2, data bit 4 (cycle 2*100 + 5*10 + 5 after acceptance).
    @(negedge clk);
    ctype[1] = 1'b1; cdata[1] = 32'hDEADBEEF; valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (255) @(negedge clk);
    chk("midreset busy_before", 32'(bsy[1]), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("midreset tx_line", 32'(txl[1]), 32'd1);
    chk("midreset busy", 32'(bsy[1]), 32'd0);
    chk("midreset ready", 32'(ready[1]), 32'd1);
    chk("midreset frame_done", 32'(fdone[1]), 32'd0);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (fdone[1] !== 1'b0 || txl[1] !== 1'b1) stray++;
    end
    chk("midreset quiet_after", stray, 0);
    ctype[1] = 1'b1; cdata[1] = 32'h01020304; valid[1] = 1'b1;
    e = '{8'h53, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    run_frame(1, 10, 0, 5, e, "after_reset", 1'b0);

    // Two gap bits, 11 clocks per bit: 12*11 cycles per byte; checksum 80^01^7E^3C = C3.
    @(negedge clk);
    ctype[2] = 1'b0; cdata[2] = 32'h80017E3C; valid[2] = 1'b1;
    e = '{8'h47, 8'h80, 8'h01, 8'h7E, 8'h3C, 8'hC3};
    run_frame(2, 11, 2, 6, e, "gap2", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
